// File: rtl/uart_rx_fifo_if.sv
// Byte stream between the UART receiver, the receive FIFO and the LCD driver.
// The receiver's strobe and the display's valid/ready handshake share one bundle.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO that buffers UART receiver bytes for the LCD driver.
// Tracks occupancy and counts bytes dropped while the FIFO is full.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_rx_fifo_if.slave bus,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          clr_ovf
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              push;
    logic              pop;
    logic              drop;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = mem[rp];

    // A write at full is still accepted when the head leaves in the same cycle.
    assign pop  = bus.rd_valid && bus.rd_ready;
    assign push = bus.wr_valid && (!full || pop);
    assign drop = bus.wr_valid && full && !pop;

    // NOTE: storage has no reset; every slot is written before it can be read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= bus.wr_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the tally at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf = 1'b0;

    uart_rx_fifo_if #(.DATA_W(8)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] q[$];
    bit         m_ovf  = 1'b0;
    int         m_drop = 0;
    logic [7:0] popped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(q[0]));
        end
    endtask

    // One clock: drive at the falling edge, advance the model, check after the rising edge.
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                         input logic clr, input bit full_check);
        bit pop_m;
        bit push_m;
        bit drop_m;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        clr_ovf      = clr;
        pop_m  = rr && (q.size() != 0);
        push_m = wv && (q.size() < DEPTH || pop_m);
        drop_m = wv && (q.size() == DEPTH) && !pop_m;
        if (pop_m) begin
            popped = bus.rd_data;
            check("pop_data", 32'(popped), 32'(q[0]));
            void'(q.pop_front());
        end
        if (push_m) q.push_back(wd);
        if (drop_m) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        clr_ovf      = 1'b0;
        if (full_check) check_state("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        do_reset();
        #1 check_state("post_reset");

        // Asynchronous reset in the middle of operation with five bytes held.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
        check("pre_reset_count", 32'(count), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        q.delete();
        check_state("async_reset");
        check("async_reset_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte with one-cycle write-to-read latency.
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        check("single_data", 32'(bus.rd_data), 32'h41);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("single_empty", 32'(empty), 32'd1);

        // Fill, partial drain, refill across the wrap, then drain fully.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("wrap_order", 32'(popped), 32'(8 + i));
        end
        check("wrap_count", 32'(count), 32'd0);

        // Overflow drops, sticky flag, then clear.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("ovf_order", 32'(popped), 32'(i));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);

        // Push and pop together while full; then clear coinciding with a drop.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        check("fullpp_pop", 32'(popped), 32'h60);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hDD, 1'b0, 1'b1, 1'b1);
        check("clr_drop_ovf", 32'(overflow), 32'd1);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("fullpp_last", 32'(popped), 32'h5A);

        // Saturation of the drop counter at 255.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check_state("saturate");
        check("saturate_cnt", 32'(drop_cnt), 32'd255);
        do_reset();

        // Sustained streaming with the consumer always ready.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0, 1'b1);
            check("stream_count_le1", 32'(count <= 5'd1), 32'd1);
        end
        check("stream_ovf", 32'(overflow), 32'd0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(99) < 60), 8'($urandom_range(255)),
                  1'($urandom_range(99) < 45), 1'($urandom_range(99) < 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
